multi_back_end: RTL
===================

// Module: multi_back_end
// PURPOSE
// - Multi-channel successor of the single-port FSL output back end. Drains NUM_CH actor output
//   ports onto one FSL master link, strictly in channel order 0..NUM_CH-1.
// - Each channel sends its own token count, latched at start. endsend rises once every channel is done.
// - Sits between the co-processor actor outputs and the FSL master interface toward the host.
// PARAMETERS
// - NUM_CH     4   number of actor output channels (>=1)
// - DATA_W     32  token / FSL data width
// - SIZECOUNT  12  width of each per-channel token counter and size field
// - CH_W       2   width of ch_sel; must satisfy 2**CH_W >= NUM_CH
// PORTS
// - clk            in   1                 clock
// - rst            in   1                 asynchronous, active-high reset
// - start          in   1                 pulse: latch size, begin transfer at channel 0
// - clear          in   1                 synchronous abort: counters to 0, FSM to IDLE
// - size           in   NUM_CH*SIZECOUNT  per-channel token count, channel i at [i*SIZECOUNT +: SIZECOUNT]
// - FSL_M_WRITE    out  1                 FSL master write strobe
// - FSL_M_DATA     out  DATA_W            FSL master data
// - FSL_M_FULL     in   1                 FSL master FIFO full
// - OUT_send       in   NUM_CH            per-channel actor send request
// - OUT_data       in   NUM_CH*DATA_W     per-channel actor data
// - IN_ack         out  NUM_CH            per-channel token accepted (equals the write strobe)
// - IN_rdy         out  NUM_CH            per-channel ready
// - ch_sel         out  CH_W              index of the channel currently sending
// - endsend        out  1                 all channels complete
// BEHAVIOUR
// - Reset values: FSM=IDLE; ch_sel=0; counters=0; size_q=0; endsend=0.
//   All combinational outputs are 0 in IDLE.
// - FSM states:
//   - IDLE: on start, go to SEND with ch_sel = first channel whose size != 0.
//     If every size is 0, go directly to DONE.
//   - SEND: stream the selected channel (rules below).
//   - DONE: endsend=1. Hold until clear (to IDLE) or start (relatch, as from IDLE).
// - start in SEND is ignored. clear has priority over start in every state.
// - Write strobe in SEND:
//   - FSL_M_WRITE = OUT_send[ch_sel] & !FSL_M_FULL & (cnt != size_q[ch_sel]).
//   - This path is purely combinational: zero-cycle latency from actor to FSL.
//   - FSL_M_DATA = OUT_data[ch_sel]; it is 0 when no channel is selected.
//   - IN_ack[i] = FSL_M_WRITE & (i == ch_sel).
//   - IN_rdy[i] = !FSL_M_FULL & (i == ch_sel) & state==SEND. Non-selected channels see rdy=0 and ack=0.
// - Counting:
//   - cnt increments on every FSL_M_WRITE.
//   - When a write makes cnt == size_q[ch_sel], the next cycle advances ch_sel to the next channel
//     with nonzero size and resets cnt to 0. If no such channel exists, go to DONE.
//   - There are no idle cycles between channels other than that single advance cycle.
// - Widths:
//   - cnt is SIZECOUNT bits and never wraps: the compare stops writes at size.
//   - The maximum is 2**SIZECOUNT-1 tokens per channel.
// - Boundaries:
//   - FSL_M_FULL stalls the selected channel only; no token is lost or duplicated.
//   - OUT_send on a non-selected channel is ignored (no ack).
//   - size changes after start have no effect.
//   - rst mid-transfer returns immediately to the reset values.
//   - clear mid-transfer takes effect next edge; the current-cycle write, if any, still completes.
// CONFIGURATION
// - Macro BE_LAST_TAG_EN.
// - Defined:
//   - Adds output FSL_M_CONTROL (1 bit) = FSL_M_WRITE & (cnt == size_q[ch_sel]-1).
//   - This marks the last token of each channel for the host.
// - Undefined:
//   - The port is absent and no tag logic is built.
//   - All other behaviour is identical.
// TESTING
// - Seq basic:
//   - Stimulus: NUM_CH=4, size={3,2,1,4} (ch0=3), all OUT_send=1, FULL=0, start.
//   - Response: 10 consecutive-per-channel writes, ch_sel 0,1,2,3, one advance bubble between
//     channels, endsend=1 after the 4th ch3 write.
// - Zero skip:
//   - Stimulus: size={0,5,0,2}.
//   - Response: ch0 and ch2 never acked; 5 writes on ch1 then 2 on ch3; all sizes 0 -> endsend
//     one cycle after start.
// - Backpressure:
//   - Stimulus: FULL toggles 1/0 every 2 cycles during ch1, size[1]=6.
//   - Response: exactly 6 acks on ch1; FSL_M_WRITE=0 whenever FULL=1; data order preserved.
// - Channel isolation:
//   - Stimulus: ch2 asserts OUT_send with data 0xDEAD while ch0 is selected.
//   - Response: IN_ack[2]=0, FSL_M_DATA shows ch0 data only.
// - Abort:
//   - Stimulus: clear after 2 of 3 ch0 tokens, then start with size={1,1,1,1}.
//   - Response: IDLE; the new transfer sends 4 tokens; async rst mid-ch1 zeroes all outputs
//     without waiting for a clock.
// - Tag (BE_LAST_TAG_EN):
//   - Stimulus: size={3,2,1,4}.
//   - Response: FSL_M_CONTROL=1 on writes 3, 5, 6 and 10 only.

Source files
------------

// File: rtl/multi_back_end_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_back_end_if
//  Purpose  : Bundles the FSL master link and the per-channel actor handshake
//             of multi_back_end into one interface.
//  Signals  : FSL_M_WRITE/FSL_M_DATA/FSL_M_FULL  - FSL master link
//             FSL_M_CONTROL                      - last-token tag (BE_LAST_TAG_EN)
//             OUT_send/OUT_data                  - actor send request and data
//             IN_ack/IN_rdy                      - per-channel accept and ready
//  Modports : master - the back end (drives FSL and actor acks)
//             slave  - the environment (actors and FSL FIFO)
//  Macro    : BE_LAST_TAG_EN adds FSL_M_CONTROL
//  Revision : 1.0 - initial release
// ============================================================================
interface multi_back_end_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
) ();
    logic                     FSL_M_WRITE;
    logic [DATA_W-1:0]        FSL_M_DATA;
    logic                     FSL_M_FULL;
`ifdef BE_LAST_TAG_EN
    logic                     FSL_M_CONTROL;
`endif
    logic [NUM_CH-1:0]        OUT_send;
    logic [NUM_CH*DATA_W-1:0] OUT_data;
    logic [NUM_CH-1:0]        IN_ack;
    logic [NUM_CH-1:0]        IN_rdy;

`ifdef BE_LAST_TAG_EN
    modport master (
        output FSL_M_WRITE, FSL_M_DATA, FSL_M_CONTROL, IN_ack, IN_rdy,
        input  FSL_M_FULL, OUT_send, OUT_data
    );
    modport slave (
        input  FSL_M_WRITE, FSL_M_DATA, FSL_M_CONTROL, IN_ack, IN_rdy,
        output FSL_M_FULL, OUT_send, OUT_data
    );
`else
    modport master (
        output FSL_M_WRITE, FSL_M_DATA, IN_ack, IN_rdy,
        input  FSL_M_FULL, OUT_send, OUT_data
    );
    modport slave (
        input  FSL_M_WRITE, FSL_M_DATA, IN_ack, IN_rdy,
        output FSL_M_FULL, OUT_send, OUT_data
    );
`endif
endinterface
`default_nettype wire

// File: rtl/multi_back_end.sv
`default_nettype none
// ============================================================================
//  Module   : multi_back_end
//  Purpose  : Drains NUM_CH actor output channels onto one FSL master link in
//             channel order 0..NUM_CH-1. Each channel sends the token count
//             latched at start; channels with a zero count are skipped.
//             endsend rises once every channel is done.
//  Ports    : clk, rst      - clock, asynchronous active-high reset
//             start         - pulse: latch size, begin at first nonzero channel
//             clear         - synchronous abort back to IDLE (beats start)
//             size          - per-channel token counts, ch i at [i*SIZECOUNT +: SIZECOUNT]
//             ch_sel        - index of the channel currently sending
//             endsend       - all channels complete
//             bus (master)  - FSL master link and actor handshake
//  Macro    : BE_LAST_TAG_EN adds FSL_M_CONTROL, high on each channel's last write
//  Revision : 1.0 - initial release
// ============================================================================
module multi_back_end #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 32,
    parameter int SIZECOUNT = 12,
    parameter int CH_W      = 2
) (
    input  wire                          clk,
    input  wire                          rst,
    input  wire                          start,
    input  wire                          clear,
    input  wire [NUM_CH*SIZECOUNT-1:0]   size,
    output logic [CH_W-1:0]              ch_sel,
    output logic                         endsend,
    multi_back_end_if.master             bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SIZECOUNT-1:0] r_size_q [NUM_CH];
    logic [SIZECOUNT-1:0] r_cnt;
    logic [SIZECOUNT-1:0] w_cnt_nxt;
    logic [CH_W-1:0]      r_ch_sel;
    logic [CH_W-1:0]      w_ch_nxt;
    logic                 w_load;

    logic                 w_sel_send;
    logic [DATA_W-1:0]    w_sel_data;
    logic [SIZECOUNT-1:0] w_sel_size;
    logic                 w_at_size;
    logic                 w_write;

    logic                 w_first_found;
    logic [CH_W-1:0]      w_first_ch;
    logic                 w_next_found;
    logic [CH_W-1:0]      w_next_ch;

    // Selected-channel mux
    always_comb begin
        w_sel_send = 1'b0;
        w_sel_data = '0;
        w_sel_size = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch_sel == CH_W'(i)) begin
                w_sel_send = bus.OUT_send[i];
                w_sel_data = bus.OUT_data[i*DATA_W +: DATA_W];
                w_sel_size = r_size_q[i];
            end
        end
    end

    // Lowest nonzero channel of the incoming size vector (used at start), and
    // lowest nonzero latched channel above the current one (used on advance).
    // Scanning downwards lets the lowest match overwrite the others.
    always_comb begin
        w_first_found = 1'b0;
        w_first_ch    = '0;
        w_next_found  = 1'b0;
        w_next_ch     = '0;
        for (int i = NUM_CH-1; i >= 0; i--) begin
            if (size[i*SIZECOUNT +: SIZECOUNT] != '0) begin
                w_first_found = 1'b1;
                w_first_ch    = CH_W'(i);
            end
            if ((CH_W'(i) > r_ch_sel) && (r_size_q[i] != '0)) begin
                w_next_found = 1'b1;
                w_next_ch    = CH_W'(i);
            end
        end
    end

    // The count compare both blocks writes past the size and marks the single
    // advance cycle between channels.
    assign w_at_size = (r_cnt == w_sel_size);
    assign w_write   = (r_state == S_SEND) & w_sel_send & ~bus.FSL_M_FULL & ~w_at_size;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch_sel;
        w_load      = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_ch_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_load    = 1'b1;
                        w_cnt_nxt = '0;
                        if (w_first_found) begin
                            w_state_nxt = S_SEND;
                            w_ch_nxt    = w_first_ch;
                        end else begin
                            w_state_nxt = S_DONE;
                            w_ch_nxt    = '0;
                        end
                    end
                end
                S_SEND: begin
                    if (w_write) begin
                        w_cnt_nxt = r_cnt + SIZECOUNT'(1);
                    end else if (w_at_size) begin
                        w_cnt_nxt = '0;
                        if (w_next_found) begin
                            w_ch_nxt = w_next_ch;
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ch_sel <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_size_q[i] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ch_sel <= w_ch_nxt;
            if (w_load) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_size_q[i] <= size[i*SIZECOUNT +: SIZECOUNT];
                end
            end
        end
    end

    // Outputs: actor-to-FSL path is purely combinational
    always_comb begin
        bus.IN_ack = '0;
        bus.IN_rdy = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch_sel == CH_W'(i)) begin
                bus.IN_ack[i] = w_write;
                bus.IN_rdy[i] = (r_state == S_SEND) & ~bus.FSL_M_FULL;
            end
        end
    end

    assign bus.FSL_M_WRITE = w_write;
    assign bus.FSL_M_DATA  = (r_state == S_SEND) ? w_sel_data : '0;
    assign ch_sel          = r_ch_sel;
    assign endsend         = (r_state == S_DONE);

`ifdef BE_LAST_TAG_EN
    assign bus.FSL_M_CONTROL = w_write & (r_cnt == (w_sel_size - SIZECOUNT'(1)));
`endif

endmodule
`default_nettype wire
